// File: rtl/spi_coax_pkg.sv
// Shared definitions for the SPI-coax link framer/deframer pair.
package spi_coax_pkg;

    localparam int FRAME_W   = 56;
    localparam int PAYLOAD_W = 48;
    localparam int CRC_BITS  = 40;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_CRC_POLY  = 8'h07;
    localparam logic [7:0] DEF_CRC_INIT  = 8'h00;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        SYNC_CHK = 2'd1,
        PAYLOAD  = 2'd2
    } dfr_state_t;

    // One MSB-first CRC8 step, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic       din,
                                             input logic [7:0] poly);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? poly : 8'h00);
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC8 register: init loads the seed, enable folds in one bit.
module crc8_serial
    import spi_coax_pkg::*;
#(
    parameter logic [7:0] POLY = DEF_CRC_POLY,
    parameter logic [7:0] INIT = DEF_CRC_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] crc
);

    // Seed has priority over a step; reset clears the register outright.
    always_ff @(posedge clk) begin
        if (rst)
            crc <= 8'h00;
        else if (init)
            crc <= INIT;
        else if (enable)
            crc <= crc8_step(crc, bit_in, POLY);
    end

endmodule

// File: rtl/frame_deframer_80m.sv
// Receive deframer: sync hunt/check, CRC8 check, one-deep output slot with
// overflow, frame-counter gap detection and lock tracking.
module frame_deframer_80m
    import spi_coax_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
    parameter logic [7:0]  CRC_POLY  = DEF_CRC_POLY,
    parameter logic [7:0]  CRC_INIT  = DEF_CRC_INIT,
    parameter int unsigned MAX_MISS  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        bit_ready,
    output logic [31:0] data_out,
    output logic [7:0]  frame_cnt_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        locked,
    output logic        crc_err,
    output logic        gap_err,
    output logic [15:0] crc_err_count,
    output logic [15:0] ovf_count
);

    dfr_state_t      state, state_nxt;
    logic [7:0]      sr, sr_shift;
    logic [5:0]      bit_cnt;
    logic [47:0]     payload, payload_shift;
    logic [7:0]      miss_cnt, miss_inc;
    logic [7:0]      prev_cnt, prev_nxt;
    logic            have_prev;
    logic [7:0]      crc;
    logic            crc_init, crc_en;
    logic            frame_done, frame_good, sync_miss, miss_evt;
    logic [7:0]      rx_cnt;

    crc8_serial #(.POLY(CRC_POLY), .INIT(CRC_INIT)) u_crc (
        .clk    (clk),
        .rst    (rst),
        .init   (crc_init),
        .enable (crc_en),
        .bit_in (bit_in),
        .crc    (crc)
    );

    assign sr_shift      = {sr[6:0], bit_in};
    assign payload_shift = {payload[46:0], bit_in};
    assign rx_cnt        = payload_shift[47:40];
    assign miss_inc      = miss_cnt + 8'd1;
    assign prev_nxt      = prev_cnt + 8'd1;
    assign miss_evt      = sync_miss | (frame_done & ~frame_good);

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= HUNT;
        else
            state <= state_nxt;
    end

    // Next state plus per-bit control strobes; nothing moves without bit_valid.
    always_comb begin
        state_nxt  = state;
        crc_init   = 1'b0;
        crc_en     = 1'b0;
        frame_done = 1'b0;
        frame_good = 1'b0;
        sync_miss  = 1'b0;
        if (bit_valid) begin
            case (state)
                HUNT: begin
                    if (sr_shift == SYNC_BYTE) begin
                        state_nxt = PAYLOAD;
                        crc_init  = 1'b1;
                    end
                end
                SYNC_CHK: begin
                    if (bit_cnt == 6'd7) begin
                        if (sr_shift == SYNC_BYTE) begin
                            state_nxt = PAYLOAD;
                            crc_init  = 1'b1;
                        end else begin
                            state_nxt = HUNT;
                            sync_miss = 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    crc_en = (bit_cnt < 6'(CRC_BITS));
                    if (bit_cnt == 6'(PAYLOAD_W - 1)) begin
                        frame_done = 1'b1;
                        frame_good = (payload_shift[7:0] == crc);
                        state_nxt  = frame_good ? SYNC_CHK : HUNT;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Bit counter, sync window and payload shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            sr      <= '0;
            payload <= '0;
        end else if (bit_valid) begin
            if (state_nxt != state || state == HUNT)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + 6'd1;

            // A failed sync check or CRC restarts the hunt from an empty window.
            if (miss_evt)
                sr <= '0;
            else if (state != PAYLOAD)
                sr <= sr_shift;

            if (state == PAYLOAD)
                payload <= payload_shift;
        end
    end

    // Lock tracking: any good frame locks; MAX_MISS bad frames in a row unlock.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked   <= 1'b0;
            miss_cnt <= '0;
        end else if (frame_done && frame_good) begin
            locked   <= 1'b1;
            miss_cnt <= '0;
        end else if (miss_evt) begin
            if (miss_inc >= 8'(MAX_MISS)) begin
                locked   <= 1'b0;
                miss_cnt <= '0;
            end else begin
                miss_cnt <= miss_inc;
            end
        end
    end

    // Output slot, error pulses and statistics; results appear the cycle after bit 47.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_ready     <= 1'b0;
            data_out      <= '0;
            frame_cnt_out <= '0;
            data_valid    <= 1'b0;
            crc_err       <= 1'b0;
            gap_err       <= 1'b0;
            crc_err_count <= '0;
            ovf_count     <= '0;
            prev_cnt      <= '0;
            have_prev     <= 1'b0;
        end else begin
            bit_ready <= 1'b1;
            crc_err   <= 1'b0;
            gap_err   <= 1'b0;
            if (data_valid && data_ready)
                data_valid <= 1'b0;

            if (frame_done && !frame_good) begin
                crc_err       <= 1'b1;
                crc_err_count <= sat_inc16(crc_err_count);
            end

            if (frame_done && frame_good) begin
                // The slot frees at this edge if downstream takes it now.
                if (!data_valid || data_ready) begin
                    data_out      <= payload_shift[39:8];
                    frame_cnt_out <= rx_cnt;
                    data_valid    <= 1'b1;
                end else begin
                    ovf_count <= sat_inc16(ovf_count);
                end
                // Dropped frames still advance the counter history.
                gap_err   <= have_prev && (rx_cnt != prev_nxt);
                prev_cnt  <= rx_cnt;
                have_prev <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_deframer_80m.sv
// Scoreboard bench for frame_deframer_80m: each test task drives frames bit by
// bit, pushes expected deliveries and checks pops and status inline.
module tb_frame_deframer_80m;

    logic        clk = 1'b0;
    logic        rst, bit_in, bit_valid, bit_ready;
    logic [31:0] data_out;
    logic [7:0]  frame_cnt_out;
    logic        data_valid, data_ready, locked, crc_err, gap_err;
    logic [15:0] crc_err_count, ovf_count;

    int          n_cmp = 0, n_fail = 0;
    int          crc_pulses, gap_pulses;
    bit          gaps_on = 1'b0;
    logic [39:0] sb[$];

    frame_deframer_80m dut (
        .clk           (clk),
        .rst           (rst),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .bit_ready     (bit_ready),
        .data_out      (data_out),
        .frame_cnt_out (frame_cnt_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .locked        (locked),
        .crc_err       (crc_err),
        .gap_err       (gap_err),
        .crc_err_count (crc_err_count),
        .ovf_count     (ovf_count)
    );

    always #6 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference CRC8, poly 0x07, init 0x00, MSB first over counter+data.
    function automatic logic [7:0] model_crc(input logic [39:0] d);
        logic [7:0] c = 8'h00;
        for (int i = 39; i >= 0; i--)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    // One clock: pop the scoreboard on a handshake, then sample pulses after the edge.
    task automatic cycle();
        logic [39:0] exp;
        if (!rst && data_valid === 1'b1 && data_ready === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_pop: got cnt=%02h data=%08h, required no frame", frame_cnt_out, data_out);
            end else begin
                exp = sb.pop_front();
                if ({frame_cnt_out, data_out} !== exp) begin
                    n_fail++;
                    $display("FAIL sb_pop: got cnt=%02h data=%08h, required cnt=%02h data=%08h",
                             frame_cnt_out, data_out, exp[39:32], exp[31:0]);
                end
            end
        end
        @(posedge clk);
        #1;
        if (crc_err === 1'b1) crc_pulses++;
        if (gap_err === 1'b1) gap_pulses++;
    endtask

    task automatic send_bit(input logic b, input bit rdy_now);
        if (gaps_on) begin
            repeat ($urandom_range(0, 3)) begin
                bit_valid = 1'b0;
                cycle();
            end
        end
        if (rdy_now) data_ready = 1'b1;
        bit_valid = 1'b1;
        bit_in    = b;
        cycle();
        bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cnt, input logic [31:0] data, input int flip,
                              input bit push, input bit last_ready);
        logic [55:0] f;
        f = {8'hA5, cnt, data, model_crc({cnt, data})};
        if (flip >= 0) f[flip] = ~f[flip];
        if (push) sb.push_back({cnt, data});
        for (int i = 55; i >= 0; i--)
            send_bit(f[i], (i == 0) && last_ready);
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; data_ready = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        sb.delete();
        crc_pulses = 0;
        gap_pulses = 0;
    endtask

    task automatic drain(input string name);
        data_ready = 1'b1;
        bit_valid  = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
        cycle();
        cycle();
        n_cmp++;
        if (sb.size() != 0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: pending=%0d data_valid=%b, required pending=0 data_valid=0",
                     name, sb.size(), data_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; data_ready = 1'b0;
        repeat (4) cycle();
        n_cmp++;
        if (bit_ready !== 1'b0 || data_valid !== 1'b0 || locked !== 1'b0 || crc_err !== 1'b0 ||
            gap_err !== 1'b0 || crc_err_count !== 16'h0 || ovf_count !== 16'h0 ||
            data_out !== 32'h0 || frame_cnt_out !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b dv=%b lk=%b ce=%b ge=%b cec=%h ovf=%h d=%h c=%h, required all 0",
                     bit_ready, data_valid, locked, crc_err, gap_err, crc_err_count, ovf_count,
                     data_out, frame_cnt_out);
        end
        rst = 1'b0; bit_valid = 1'b0;
        cycle();
        n_cmp++;
        if (bit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_bit_ready: got %b, required 1", bit_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_frame(8'h01, 32'hDEADBEEF, -1, 1'b1, 1'b0);
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 32'hDEADBEEF || frame_cnt_out !== 8'h01 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: dv=%b d=%h c=%h lk=%b, required dv=1 d=deadbeef c=01 lk=1",
                     data_valid, data_out, frame_cnt_out, locked);
        end
        drain("basic");
    endtask

    task automatic test_back_to_back();
        logic [4:0] junk;
        junk = 5'b01101;
        do_reset();
        for (int i = 4; i >= 0; i--) send_bit(junk[i], 1'b0);
        send_frame(8'h05, 32'h12345678, -1, 1'b1, 1'b0);
        send_frame(8'h06, 32'h9ABCDEF0, -1, 1'b1, 1'b0);
        drain("b2b");
        n_cmp++;
        if (crc_pulses != 0 || gap_pulses != 0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_status: crc=%0d gap=%0d lk=%b, required 0 0 1", crc_pulses, gap_pulses, locked);
        end
    endtask

    task automatic test_gap();
        do_reset();
        send_frame(8'hFE, 32'h00000001, -1, 1'b1, 1'b0);
        send_frame(8'hFF, 32'h00000002, -1, 1'b1, 1'b0);
        send_frame(8'h00, 32'h00000003, -1, 1'b1, 1'b0);
        n_cmp++;
        if (gap_pulses != 0) begin
            n_fail++;
            $display("FAIL gap_wrap: got %0d gap pulses, required 0", gap_pulses);
        end
        send_frame(8'h02, 32'h00000004, -1, 1'b1, 1'b0);
        drain("gap");
        n_cmp++;
        if (gap_pulses != 1) begin
            n_fail++;
            $display("FAIL gap_skip: got %0d gap pulses, required 1", gap_pulses);
        end
    endtask

    task automatic test_crc_lock();
        do_reset();
        send_frame(8'h10, 32'hCAFEF00D, -1, 1'b1, 1'b0);
        send_frame(8'h11, 32'h11112222, 28, 1'b0, 1'b0);
        n_cmp++;
        if (crc_pulses != 1 || crc_err_count !== 16'd1 || data_valid !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL crc_single: pulses=%0d cnt=%0d dv=%b lk=%b, required 1 1 0 1",
                     crc_pulses, crc_err_count, data_valid, locked);
        end
        send_frame(8'h12, 32'h33334444, 28, 1'b0, 1'b0);
        send_frame(8'h13, 32'h55556666, 12, 1'b0, 1'b0);
        n_cmp++;
        if (locked !== 1'b0 || crc_err_count !== 16'd3) begin
            n_fail++;
            $display("FAIL crc_unlock: lk=%b cnt=%0d, required lk=0 cnt=3", locked, crc_err_count);
        end
        send_frame(8'h11, 32'h77778888, -1, 1'b1, 1'b0);
        drain("crc");
        n_cmp++;
        if (locked !== 1'b1 || crc_pulses != 3 || gap_pulses != 0) begin
            n_fail++;
            $display("FAIL crc_relock: lk=%b crc=%0d gap=%0d, required 1 3 0", locked, crc_pulses, gap_pulses);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        data_ready = 1'b0;
        send_frame(8'h20, 32'hA0A0A0A0, -1, 1'b1, 1'b0);
        send_frame(8'h21, 32'hB1B1B1B1, -1, 1'b0, 1'b0);
        send_frame(8'h22, 32'hC2C2C2C2, -1, 1'b0, 1'b0);
        n_cmp++;
        if (data_valid !== 1'b1 || frame_cnt_out !== 8'h20 || data_out !== 32'hA0A0A0A0 || ovf_count !== 16'd2) begin
            n_fail++;
            $display("FAIL ovf_hold: dv=%b c=%h d=%h ovf=%0d, required 1 20 a0a0a0a0 2",
                     data_valid, frame_cnt_out, data_out, ovf_count);
        end
        send_frame(8'h23, 32'hD3D3D3D3, -1, 1'b1, 1'b1);
        n_cmp++;
        if (data_valid !== 1'b1 || frame_cnt_out !== 8'h23 || ovf_count !== 16'd2 || gap_pulses != 0) begin
            n_fail++;
            $display("FAIL ovf_reload: dv=%b c=%h ovf=%0d gap=%0d, required 1 23 2 0",
                     data_valid, frame_cnt_out, ovf_count, gap_pulses);
        end
        drain("ovf");
    endtask

    task automatic test_reset_mid_frame();
        logic [55:0] f;
        do_reset();
        gaps_on = 1'b1;
        f = {8'hA5, 8'h30, 32'h0BADF00D, model_crc({8'h30, 32'h0BADF00D})};
        for (int i = 55; i >= 26; i--) send_bit(f[i], 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        send_frame(8'h31, 32'h600DF00D, -1, 1'b1, 1'b0);
        drain("midrst");
        gaps_on = 1'b0;
        n_cmp++;
        if (crc_err_count !== 16'd0 || locked !== 1'b1 || ovf_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_status: cec=%0d lk=%b ovf=%0d, required 0 1 0",
                     crc_err_count, locked, ovf_count);
        end
    endtask

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; data_ready = 1'b0;
        crc_pulses = 0; gap_pulses = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_gap();
        test_crc_lock();
        test_overflow();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
